// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter and sequencer for one single-ported SRAM.
// Two requesters, locked bursts bounded by MAX_HOLD, registered SRAM drive.
module sram_port_arbiter #(
  parameter int AW       = 14,
  parameter int DW       = 32,
  parameter int MAX_HOLD = 8
) (
  input  logic            h_clk,
  input  logic            h_reset,
  input  logic            m0_req,
  input  logic            m0_lock,
  input  logic            m0_wen,
  input  logic [AW-1:0]   m0_addr,
  input  logic [DW/8-1:0] m0_bena,
  input  logic [DW-1:0]   m0_wdata,
  input  logic            m1_req,
  input  logic            m1_lock,
  input  logic            m1_wen,
  input  logic [AW-1:0]   m1_addr,
  input  logic [DW/8-1:0] m1_bena,
  input  logic [DW-1:0]   m1_wdata,
  output logic            m0_gnt,
  output logic            m1_gnt,
  output logic            m0_rvalid,
  output logic            m1_rvalid,
  output logic [DW-1:0]   rdata,
  output logic            sram_csn,
  output logic            sram_wen,
  output logic [AW-1:0]   sram_addr,
  output logic [DW/8-1:0] sram_bena,
  output logic [DW-1:0]   sram_wdata,
  input  logic [DW-1:0]   sram_rdata
);

  localparam int BW = DW / 8;
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } state_e;

  state_e          state_q, state_d;
  logic            last_q, last_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic            csn_q, csn_d;
  logic            wen_q, wen_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [BW-1:0]   bena_q, bena_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [1:0]      rv1_q, rv1_d;
  logic [1:0]      rv2_q, rv2_d;
  logic            acc0, acc1;

  // Next owner, burst bookkeeping, SRAM drive and read-valid tags.
  always_comb begin
    acc0    = m0_req & (state_q == OWN0);
    acc1    = m1_req & (state_q == OWN1);
    state_d = state_q;
    last_d  = last_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        if (m0_req && m1_req)
          state_d = last_q ? OWN0 : OWN1;
        else if (m0_req)
          state_d = OWN0;
        else if (m1_req)
          state_d = OWN1;
      end
      OWN0: begin
        if (!m0_req)
          state_d = m1_req ? OWN1 : IDLE;
        else if (m1_req &&
                 (!m0_lock || hold_q == HOLD_LAST))
          state_d = OWN1;
      end
      OWN1: begin
        if (!m1_req)
          state_d = m0_req ? OWN0 : IDLE;
        else if (m0_req &&
                 (!m1_lock || hold_q == HOLD_LAST))
          state_d = OWN0;
      end
      default: state_d = IDLE;
    endcase
    // Counter saturates so a long solo run still
    // bounds a later lock once the peer shows up.
    if (state_d != state_q) begin
      hold_d = '0;
      if (state_q == OWN0) last_d = 1'b0;
      if (state_q == OWN1) last_d = 1'b1;
    end else if ((acc0 || acc1) && hold_q != HOLD_LAST) begin
      hold_d = hold_q + HW'(1);
    end

    csn_d   = 1'b1;
    wen_d   = 1'b1;
    bena_d  = '1;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (acc0) begin
      csn_d   = 1'b0;
      wen_d   = m0_wen;
      addr_d  = m0_addr;
      bena_d  = m0_bena;
      wdata_d = m0_wdata;
    end else if (acc1) begin
      csn_d   = 1'b0;
      wen_d   = m1_wen;
      addr_d  = m1_addr;
      bena_d  = m1_bena;
      wdata_d = m1_wdata;
    end
    rv1_d = {acc1 & m1_wen, acc0 & m0_wen};
    rv2_d = rv1_q;
  end

  // State and SRAM registers; reset drops in-flight reads.
  always_ff @(posedge h_clk) begin
    if (h_reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      hold_q  <= '0;
      csn_q   <= 1'b1;
      wen_q   <= 1'b1;
      addr_q  <= '0;
      bena_q  <= '1;
      wdata_q <= '0;
      rv1_q   <= '0;
      rv2_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      csn_q   <= csn_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      bena_q  <= bena_d;
      wdata_q <= wdata_d;
      rv1_q   <= rv1_d;
      rv2_q   <= rv2_d;
    end
  end

  assign m0_gnt     = (state_q == OWN0);
  assign m1_gnt     = (state_q == OWN1);
  assign m0_rvalid  = rv2_q[0];
  assign m1_rvalid  = rv2_q[1];
  assign rdata      = sram_rdata;
  assign sram_csn   = csn_q;
  assign sram_wen   = wen_q;
  assign sram_addr  = addr_q;
  assign sram_bena  = bena_q;
  assign sram_wdata = wdata_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: vector table, directed
// corner sequences and random traffic against a cycle model.
module tb_sram_port_arbiter;

  localparam int AW = 14;
  localparam int DW = 32;
  localparam int MAX_HOLD = 8;

  logic h_clk = 1'b0;
  logic h_reset;
  logic m0_req, m0_lock, m0_wen;
  logic [AW-1:0] m0_addr;
  logic [3:0] m0_bena;
  logic [DW-1:0] m0_wdata;
  logic m1_req, m1_lock, m1_wen;
  logic [AW-1:0] m1_addr;
  logic [3:0] m1_bena;
  logic [DW-1:0] m1_wdata;
  logic m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DW-1:0] rdata;
  logic sram_csn, sram_wen;
  logic [AW-1:0] sram_addr;
  logic [3:0] sram_bena;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;

  always #5 h_clk = ~h_clk;

  sram_port_arbiter #(
    .AW(AW), .DW(DW), .MAX_HOLD(MAX_HOLD)
  ) dut (
    .h_clk(h_clk), .h_reset(h_reset),
    .m0_req(m0_req), .m0_lock(m0_lock),
    .m0_wen(m0_wen), .m0_addr(m0_addr),
    .m0_bena(m0_bena), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_lock(m1_lock),
    .m1_wen(m1_wen), .m1_addr(m1_addr),
    .m1_bena(m1_bena), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
    .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .rdata(rdata),
    .sram_csn(sram_csn), .sram_wen(sram_wen),
    .sram_addr(sram_addr), .sram_bena(sram_bena),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  function automatic logic [31:0] merge(
    input logic [31:0] o, input logic [31:0] n,
    input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++)
      if (!be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  // SRAM device behind the port
  bit [31:0] smem [0:16383];
  bit [31:0] rd_q;
  always @(posedge h_clk) begin
    if (!sram_csn) begin
      if (!sram_wen)
        smem[sram_addr] <= merge(smem[sram_addr],
                                 sram_wdata, sram_bena);
      else
        rd_q <= smem[sram_addr];
    end
  end
  assign sram_rdata = rd_q;

  typedef struct {
    bit lock;
    bit wen;
    logic [AW-1:0] addr;
    logic [3:0] bena;
    logic [31:0] wdata;
  } beat_t;

  typedef struct {
    bit who;
    logic [AW-1:0] addr;
    bit wen;
    logic [3:0] bena;
    int c;
  } obs_t;

  typedef struct {
    bit r0;
    logic [AW-1:0] a0;
    bit g0;
    bit csn;
    logic [AW-1:0] addr;
    bit rv0;
  } vec_t;

  beat_t q0[$];
  beat_t q1[$];
  obs_t  olog[$];
  bit use_q;
  bit prev_g1;
  logic [31:0] rd0_seen;
  int rv1_cnt;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;

  int m_own;
  bit m_last;
  int m_hold;
  bit e_csn, e_wen;
  logic [AW-1:0] e_addr;
  logic [3:0] e_bena;
  logic [31:0] e_wdata;
  bit rv0_at[int];
  bit rv1_at[int];
  logic [31:0] rd_at[int];
  bit [31:0] rmem [0:16383];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s cycle %0d: got %0h want %0h",
               nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_own = -1;
    m_last = 1'b1;
    m_hold = 0;
    e_csn = 1'b1;
    e_wen = 1'b1;
    e_bena = 4'hF;
    e_addr = '0;
    e_wdata = '0;
    rv0_at.delete();
    rv1_at.delete();
    rd_at.delete();
  endtask

  // Sample at the falling edge, then advance the model
  task automatic step_a();
    int acc, nxt, x, y;
    bit rx, ry, lk;
    @(negedge h_clk);
    chk("m0_gnt", 64'(m0_gnt), 64'(m_own == 0));
    chk("m1_gnt", 64'(m1_gnt), 64'(m_own == 1));
    chk("sram_csn", 64'(sram_csn), 64'(e_csn));
    chk("sram_wen", 64'(sram_wen), 64'(e_wen));
    chk("sram_bena", 64'(sram_bena), 64'(e_bena));
    chk("sram_addr", 64'(sram_addr), 64'(e_addr));
    chk("sram_wdata", 64'(sram_wdata), 64'(e_wdata));
    chk("m0_rvalid", 64'(m0_rvalid),
        64'(rv0_at.exists(cyc)));
    chk("m1_rvalid", 64'(m1_rvalid),
        64'(rv1_at.exists(cyc)));
    if (rd_at.exists(cyc))
      chk("rdata", 64'(rdata), 64'(rd_at[cyc]));
    if (m0_rvalid) rd0_seen = rdata;
    if (m1_rvalid) rv1_cnt++;
    if (!sram_csn)
      olog.push_back('{prev_g1, sram_addr, sram_wen,
                       sram_bena, cyc});
    prev_g1 = m1_gnt;
    if (h_reset) begin
      model_reset();
    end else begin
      acc = -1;
      if (m_own == 0 && m0_req) acc = 0;
      if (m_own == 1 && m1_req) acc = 1;
      e_csn = 1'b1;
      e_wen = 1'b1;
      e_bena = 4'hF;
      if (acc >= 0) begin
        e_csn = 1'b0;
        e_wen = (acc == 1) ? m1_wen : m0_wen;
        e_addr = (acc == 1) ? m1_addr : m0_addr;
        e_bena = (acc == 1) ? m1_bena : m0_bena;
        e_wdata = (acc == 1) ? m1_wdata : m0_wdata;
        if (e_wen) begin
          if (acc == 1) rv1_at[cyc+2] = 1'b1;
          else rv0_at[cyc+2] = 1'b1;
          rd_at[cyc+2] = rmem[e_addr];
        end else begin
          rmem[e_addr] = merge(rmem[e_addr],
                               e_wdata, e_bena);
        end
        if (use_q) begin
          if (acc == 1) void'(q1.pop_front());
          else void'(q0.pop_front());
        end
      end
      if (m_own < 0) begin
        if (m0_req && m1_req) nxt = m_last ? 0 : 1;
        else if (m0_req) nxt = 0;
        else if (m1_req) nxt = 1;
        else nxt = -1;
      end else begin
        x = m_own;
        y = 1 - x;
        rx = (x == 1) ? m1_req : m0_req;
        ry = (x == 1) ? m0_req : m1_req;
        lk = (x == 1) ? m1_lock : m0_lock;
        if (!rx) nxt = ry ? y : -1;
        else if (ry && (!lk || m_hold == MAX_HOLD-1))
          nxt = y;
        else nxt = x;
      end
      if (nxt != m_own) begin
        if (m_own >= 0) m_last = (m_own == 1);
        m_hold = 0;
      end else if (acc >= 0 && m_hold < MAX_HOLD-1) begin
        m_hold++;
      end
      m_own = nxt;
    end
  endtask

  task automatic step_b();
    @(posedge h_clk);
    #1;
    cyc++;
  endtask

  task automatic drive_q();
    m0_req = (q0.size() > 0);
    m1_req = (q1.size() > 0);
    m0_lock = 1'b0;
    m1_lock = 1'b0;
    if (q0.size() > 0) begin
      m0_lock = q0[0].lock;
      m0_wen = q0[0].wen;
      m0_addr = q0[0].addr;
      m0_bena = q0[0].bena;
      m0_wdata = q0[0].wdata;
    end
    if (q1.size() > 0) begin
      m1_lock = q1[0].lock;
      m1_wen = q1[0].wen;
      m1_addr = q1[0].addr;
      m1_bena = q1[0].bena;
      m1_wdata = q1[0].wdata;
    end
  endtask

  task automatic run_q(input int maxc);
    for (int i = 0; i < maxc; i++) begin
      if (q0.size() == 0 && q1.size() == 0) break;
      drive_q();
      step_a();
      step_b();
    end
    chk("drain", 64'(q0.size() + q1.size()), 64'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive_q();
      step_a();
      step_b();
    end
  endtask

  task automatic do_reset();
    h_reset = 1'b1;
    drive_q();
    step_a();
    step_b();
    h_reset = 1'b0;
  endtask

  function automatic beat_t mk(input bit lk, input bit w,
                               input int a,
                               input logic [3:0] be,
                               input logic [31:0] d);
    beat_t b;
    b.lock = lk;
    b.wen = w;
    b.addr = AW'(a);
    b.bena = be;
    b.wdata = d;
    return b;
  endfunction

  initial begin
    #5ms;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    beat_t b;
    tbl[0] = '{1'b1, 14'h10, 1'b0, 1'b1, 14'h00, 1'b0};
    tbl[1] = '{1'b1, 14'h10, 1'b1, 1'b1, 14'h00, 1'b0};
    tbl[2] = '{1'b1, 14'h11, 1'b1, 1'b0, 14'h10, 1'b0};
    tbl[3] = '{1'b1, 14'h12, 1'b1, 1'b0, 14'h11, 1'b1};
    tbl[4] = '{1'b1, 14'h13, 1'b1, 1'b0, 14'h12, 1'b1};
    tbl[5] = '{1'b0, 14'h13, 1'b1, 1'b0, 14'h13, 1'b1};
    tbl[6] = '{1'b0, 14'h13, 1'b0, 1'b1, 14'h13, 1'b1};
    tbl[7] = '{1'b0, 14'h13, 1'b0, 1'b1, 14'h13, 1'b0};

    h_reset = 1'b1;
    use_q = 1'b0;
    prev_g1 = 1'b0;
    rv1_cnt = 0;
    rd0_seen = '0;
    drive_q();
    m0_wen = 1'b1; m0_addr = '0;
    m0_bena = 4'hF; m0_wdata = '0;
    m1_wen = 1'b1; m1_addr = '0;
    m1_bena = 4'hF; m1_wdata = '0;
    repeat (2) @(posedge h_clk);
    #1;
    model_reset();
    h_reset = 1'b0;

    // read burst, then owner drops req with m1 idle
    for (int i = 0; i < 8; i++) begin
      m0_req = tbl[i].r0;
      m0_addr = tbl[i].a0;
      m0_wen = 1'b1;
      m0_lock = 1'b0;
      m0_bena = 4'hF;
      m1_req = 1'b0;
      step_a();
      chk("tbl_gnt0", 64'(m0_gnt), 64'(tbl[i].g0));
      chk("tbl_csn", 64'(sram_csn), 64'(tbl[i].csn));
      chk("tbl_addr", 64'(sram_addr), 64'(tbl[i].addr));
      chk("tbl_rv0", 64'(m0_rvalid), 64'(tbl[i].rv0));
      step_b();
    end
    use_q = 1'b1;

    // simultaneous requests after reset alternate
    do_reset();
    olog.delete();
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(1'b0, 1'b1, 'h20 + i, 4'hF, 0));
      q1.push_back(mk(1'b0, 1'b1, 'h30 + i, 4'hF, 0));
    end
    run_q(40);
    idle(3);
    chk("alt_len", 64'(olog.size()), 64'd8);
    if (olog.size() == 8)
      for (int i = 0; i < 8; i++) begin
        chk("alt_who", 64'(olog[i].who), 64'(i % 2));
        chk("alt_gap", 64'(olog[i].c),
            64'(olog[0].c + i));
      end

    // locked write burst bounded by MAX_HOLD
    do_reset();
    olog.delete();
    for (int i = 0; i < 20; i++)
      q0.push_back(mk(1'b1, 1'b0, 'h200 + i,
                      4'($urandom), $urandom));
    q1.push_back(mk(1'b0, 1'b0, 'h300, 4'h0, 32'h5A5A));
    run_q(100);
    idle(2);
    chk("lk_len", 64'(olog.size()), 64'd21);
    if (olog.size() >= 10) begin
      for (int i = 0; i < 8; i++) begin
        chk("lk_who", 64'(olog[i].who), 64'd0);
        chk("lk_wen", 64'(olog[i].wen), 64'd0);
      end
      chk("lk_m1", 64'(olog[8].who), 64'd1);
      chk("lk_back", 64'(olog[9].who), 64'd0);
    end

    // m1 partial write, m0 reads it back
    olog.delete();
    q1.push_back(mk(1'b0, 1'b0, 'h100, 4'b1100,
                    32'hDEADBEEF));
    run_q(20);
    q0.push_back(mk(1'b0, 1'b1, 'h100, 4'hF, 0));
    run_q(20);
    idle(3);
    if (olog.size() >= 1)
      chk("wr_bena", 64'(olog[0].bena), 64'(4'b1100));
    chk("rd_back", 64'(rd0_seen), 64'h0000BEEF);

    // reset right after an accepted m1 read
    q1.push_back(mk(1'b0, 1'b1, 'h40, 4'hF, 0));
    run_q(20);
    rv1_cnt = 0;
    do_reset();
    idle(4);
    chk("rst_rv1", 64'(rv1_cnt), 64'd0);
    olog.delete();
    q0.push_back(mk(1'b0, 1'b1, 'h41, 4'hF, 0));
    q1.push_back(mk(1'b0, 1'b1, 'h42, 4'hF, 0));
    run_q(20);
    idle(3);
    if (olog.size() >= 1)
      chk("rst_tie", 64'(olog[0].who), 64'd0);

    // random traffic against the model
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        q0.delete();
        q1.delete();
        do_reset();
      end
      for (int k = 0; k < 2; k++) begin
        b = mk(($urandom_range(0, 2) == 0),
               $urandom_range(0, 1),
               $urandom_range(0, 15),
               4'($urandom), $urandom);
        if ($urandom_range(0, 2) != 0) begin
          if (k == 0 && q0.size() == 0) q0.push_back(b);
          if (k == 1 && q1.size() == 0) q1.push_back(b);
        end
      end
      drive_q();
      step_a();
      step_b();
    end
    q0.delete();
    q1.delete();
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
